// File: rtl/predecode_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : predecode_inst_buffer
//  Description : Fetch-to-decode instruction queue. Every entering
//                instruction is pre-decoded into a branch class that is
//                stored with the entry. A branch/jump at the head is only
//                released to ID once its delay-slot instruction is also
//                buffered. Supports a flush for exception/ERET redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module predecode_inst_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  // IF side
  input  logic                     fs_to_ib_valid,
  output logic                     ib_allow_in,
  input  logic [PC_W-1:0]          fs_pc,
  input  logic [31:0]              fs_inst,
  // ID side
  output logic                     ib_to_ds_valid,
  input  logic                     ds_allow_in,
  output logic [PC_W-1:0]          ib_pc,
  output logic [31:0]              ib_inst,
  output logic                     ib_is_branch,
  output logic [2:0]               ib_br_kind,
  output logic [$clog2(DEPTH):0]   ib_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Branch classes held in the kind field of each entry
  localparam logic [2:0] KIND_NONE      = 3'd0;
  localparam logic [2:0] KIND_COND      = 3'd1;
  localparam logic [2:0] KIND_COND_LINK = 3'd2;
  localparam logic [2:0] KIND_J         = 3'd3;
  localparam logic [2:0] KIND_JAL       = 3'd4;
  localparam logic [2:0] KIND_JR        = 3'd5;
  localparam logic [2:0] KIND_JALR      = 3'd6;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage (not reset; only meaningful for occupied slots)
  logic [PC_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]     r_inst_mem [DEPTH];
  logic [2:0]      r_kind_mem [DEPTH];

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [5:0]      w_op;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_sa;
  logic [5:0]      w_func;
  logic [2:0]      w_new_kind;
  logic [2:0]      w_head_kind;
  logic            w_push;
  logic            w_pop;

  assign w_op   = fs_inst[31:26];
  assign w_rt   = fs_inst[20:16];
  assign w_rd   = fs_inst[15:11];
  assign w_sa   = fs_inst[10:6];
  assign w_func = fs_inst[5:0];

  // Pre-decode the incoming instruction into its branch class
  always_comb begin
    w_new_kind = KIND_NONE;
    case (w_op)
      6'h04, 6'h05: w_new_kind = KIND_COND;
      6'h06, 6'h07: begin
        if (w_rt == 5'h00) w_new_kind = KIND_COND;
      end
      6'h01: begin
        case (w_rt)
          5'h00, 5'h01: w_new_kind = KIND_COND;
          5'h10, 5'h11: w_new_kind = KIND_COND_LINK;
          default:      w_new_kind = KIND_NONE;
        endcase
      end
      6'h02: w_new_kind = KIND_J;
      6'h03: w_new_kind = KIND_JAL;
      6'h00: begin
        if (w_func == 6'h08 && w_rt == 5'h00 && w_rd == 5'h00 && w_sa == 5'h00)
          w_new_kind = KIND_JR;
        else if (w_func == 6'h09 && w_rt == 5'h00 && w_sa == 5'h00)
          w_new_kind = KIND_JALR;
      end
      default: w_new_kind = KIND_NONE;
    endcase
  end

  // A full buffer refuses input even when the head is leaving this cycle
  assign ib_allow_in = !reset && !flush && (r_count < FULL_COUNT);
  assign w_push      = fs_to_ib_valid && ib_allow_in;

  // A branch head is held back until its delay slot sits behind it
  assign w_head_kind    = r_kind_mem[r_head];
  assign ib_to_ds_valid = (r_count != '0) &&
                          ((w_head_kind == KIND_NONE) || (r_count >= CW'(2)));
  assign w_pop          = ib_to_ds_valid && ds_allow_in;

  assign ib_pc        = r_pc_mem[r_head];
  assign ib_inst      = r_inst_mem[r_head];
  assign ib_br_kind   = w_head_kind;
  assign ib_is_branch = (w_head_kind != KIND_NONE);
  assign ib_count     = r_count;

  // Pointer and occupancy update; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the accepted instruction and its class into the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= fs_pc;
      r_inst_mem[r_tail] <= fs_inst;
      r_kind_mem[r_tail] <= w_new_kind;
    end
  end

endmodule
`default_nettype wire
